// File: rtl/result_to_bcd.sv
// Binary magnitude + sign to four BCD digits using iterative double-dabble,
// with start/busy/done handshake, leading-zero blanking and overflow saturation.
module result_to_bcd #(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             neg_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dig0,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic             negsign,
    output logic [3:0]       blank,
    output logic             ovf
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      bcd, bcd_adj;
    logic [BIN_W-1:0] bin_sr, mag_q;
    logic             neg_q;
    logic             capture, shift_en, load_out;
    logic             ovf_c, z3, z2, z1;
    logic [15:0]      res;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        capture  = (state == IDLE) && start;
        shift_en = (state == SHIFT);
        load_out = (state == DONE);
    end

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Overflow saturates the display; blanking works on the shown digits.
    assign ovf_c = (mag_q > BIN_W'(MAX_VAL));
    assign res   = ovf_c ? 16'h9999 : bcd;
    assign z3    = (res[15:12] == 4'd0);
    assign z2    = z3 && (res[11:8] == 4'd0);
    assign z1    = z2 && (res[7:4] == 4'd0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bcd     <= '0;
            bin_sr  <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dig0    <= '0;
            dig1    <= '0;
            dig2    <= '0;
            dig3    <= '0;
            negsign <= 1'b0;
            blank   <= 4'b1110;
            ovf     <= 1'b0;
        end else begin
            done <= load_out;
            if (capture) begin
                bin_sr <= bin_in;
                mag_q  <= bin_in;
                neg_q  <= neg_in;
                bcd    <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
            end else if (shift_en) begin
                {bcd, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
                cnt           <= cnt + CNT_W'(1);
            end
            if (load_out) begin
                busy    <= 1'b0;
                dig0    <= res[3:0];
                dig1    <= res[7:4];
                dig2    <= res[11:8];
                dig3    <= res[15:12];
                negsign <= neg_q && (mag_q != '0);
                blank   <= {z3, z2, z1, 1'b0};
                ovf     <= ovf_c;
            end
        end
    end
endmodule
